rgb_interp_pixel_fetch: RTL and testbench
=========================================

Name: rgb_interp_pixel_fetch

Overview:
- Read-side stage that feeds the VGA output path. Reads a packed 8-bit RGB image from external SRAM through the SRAM controller.
- Emits one pixel per handshake, applying 2-tap horizontal interpolation: first column passes through raw, every other column is the average of the previous and current source pixels.
- Output stream goes to the VGA pixel register, which consumes at most one pixel every other 50 MHz cycle.

Parameters:
- BASE_ADDR, 18'd0, SRAM word address of the first RGB word.
- IMG_WIDTH, 320, pixels per row; must be even.
- IMG_HEIGHT, 240, rows per frame.
- SRAM_LATENCY, 2, cycles from address to valid SRAM_read_data.
- FIFO_DEPTH, 8, word FIFO entries; power of 2, at least SRAM_LATENCY+2.

Ports:
- Clock  in  1  50 MHz system clock.
- Resetn  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse, begins a frame; ignored while Busy.
- Busy  out  1  high from the cycle after accepted Start until Done.
- Done  out  1  one-cycle pulse after the last pixel is accepted.
- SRAM_address  out  18  read address.
- SRAM_we_n  out  1  constant 1; block never writes.
- SRAM_read_data  in  16  read data, valid SRAM_LATENCY cycles after address.
- Pixel_valid  out  1  output pixel available.
- Pixel_ready  in  1  downstream accepts when high with Pixel_valid.
- Pixel_red, Pixel_green, Pixel_blue  out  8 each  output colour.
- Pixel_sol  out  1  qualifies column 0.
- Pixel_eof  out  1  qualifies the last pixel of the frame.
- Checksum  out  24  see Optional Feature.

Behaviour:
- Reset: every output is 0 except SRAM_we_n=1 and SRAM_address=BASE_ADDR. FSM goes to S_IDLE, FIFO is emptied, in-flight reads are discarded.
- Memory layout:
  - Bytes are sequential R,G,B; each word holds byte 2k in [15:8] and byte 2k+1 in [7:0].
  - Pixel pair p occupies words 3p..3p+2: W0={R0,G0}, W1={B0,R1}, W2={G1,B1}.
  - Frame size is IMG_HEIGHT*IMG_WIDTH*3/2 words (115200 at defaults).
- FSM:
  - S_IDLE: on Start go to S_FETCH, clear counters, raise Busy.
  - S_FETCH: issue one read per cycle while (fifo_count + in_flight) < FIFO_DEPTH. Address increments by 1 per issue. After the last word is issued go to S_DRAIN.
  - S_DRAIN: wait until all in-flight data is received and the final pixel is accepted. Then pulse Done, drop Busy, return to S_IDLE.
- Read data path:
  - Returning data is captured into the FIFO exactly SRAM_LATENCY cycles after issue, using a shift-register valid tag.
  - The FIFO never overflows; a credit violation is a design error.
- Unpacker: pops W0,W1,W2 and produces pixel pair (P0,P1) into a 2-entry pixel stage. It pops only when that stage has space.
- Interpolator:
  - Holds prev pixel. Column 0 outputs the raw pixel and loads prev.
  - Column c>0 outputs each channel as (prev+cur)>>1 using a 9-bit sum with truncation, then loads prev=cur.
  - Column counter wraps at IMG_WIDTH−1 into a row counter; prev is not carried across rows.
- Output handshake:
  - A transfer occurs when Pixel_valid && Pixel_ready.
  - While Pixel_valid && !Pixel_ready, all Pixel_* outputs hold stable.
  - Pixel_valid never drops without a transfer.
  - Back-to-back transfers at one per cycle are supported.
- Boundary conditions:
  - Start while Busy: ignored.
  - Start coinciding with Done: ignored; a new Start is required the following cycle or later.
  - Resetn asserted mid-frame: immediate return to reset state. No partial Done. The next frame restarts from BASE_ADDR.
  - SRAM_address never exceeds BASE_ADDR + words − 1.

Optional Feature:
- Macro: RGB_INTERP_CHECKSUM_EN.
- When defined: Checksum is a 24-bit wrapping sum of {Pixel_red,Pixel_green,Pixel_blue} over every transferred pixel. It clears on accepted Start and holds its final value after Done.
- When undefined: Checksum is tied to 0 and no accumulator logic exists.

Test Plan:
- Uniform image, every pixel (0x0A,0x14,0x1E), Pixel_ready=1 → exactly 76800 transfers, all (0A,14,1E), one Done, Busy low after; Pixel_eof only on transfer 76800.
- Row 0 pixel0 R=0x00, pixel1 R=0xFF, pixel2 R=0x01 → outputs R 0x00, 0x7F, 0x80. Row 1 col 0 equals raw source pixel 320 with Pixel_sol=1.
- Pixel_ready high 1 cycle in 3, pseudo-random pattern → output sequence identical to the unstalled run; outputs stable during stalls; SRAM_address max 115199.
- Resetn pulsed low after 1000 transfers → all outputs at reset values next edge; new Start gives first pixel equal to source pixel 0; no Done from the aborted frame.
- Start pulsed at transfer 500 and in the same cycle as Done → both ignored; total transfers stay 76800.
- With RGB_INTERP_CHECKSUM_EN on the uniform image → Checksum = (76800 × 0x0A141E) mod 2^24 after Done; without the macro, Checksum=0.

Source files
------------

// File: rtl/rgb_interp_pixel_fetch.sv
// rgb_interp_pixel_fetch: reads a packed 8-bit RGB frame from SRAM and emits
// one pixel per valid/ready handshake with 2-tap horizontal interpolation.
// Column 0 of each row passes through raw. Every other column is
// (prev + cur) >> 1 per channel.
// Optional feature macro: RGB_INTERP_CHECKSUM_EN (24-bit running sum of
// transferred pixels). When it is undefined, Checksum_o is tied to 0.
module rgb_interp_pixel_fetch #(
  parameter logic [17:0] BASE_ADDR    = 18'd0,
  parameter int          IMG_WIDTH    = 320,
  parameter int          IMG_HEIGHT   = 240,
  parameter int          SRAM_LATENCY = 2,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        Clock_i,
  input  logic        Resetn_i,
  input  logic        Start_i,
  output logic        Busy_o,
  output logic        Done_o,
  output logic [17:0] SRAM_address_o,
  output logic        SRAM_we_n_o,
  input  logic [15:0] SRAM_read_data_i,
  output logic        Pixel_valid_o,
  input  logic        Pixel_ready_i,
  output logic [7:0]  Pixel_red_o,
  output logic [7:0]  Pixel_green_o,
  output logic [7:0]  Pixel_blue_o,
  output logic        Pixel_sol_o,
  output logic        Pixel_eof_o,
  output logic [23:0] Checksum_o
);

  localparam int          WORDS     = IMG_HEIGHT * IMG_WIDTH * 3 / 2;
  localparam logic [17:0] LAST_ADDR = BASE_ADDR + 18'(WORDS - 1);
  localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          OW        = $clog2(FIFO_DEPTH + SRAM_LATENCY + 1);
  localparam int          CW        = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int          RW        = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  state_e      state_q;
  logic        busy_q, done_q;
  logic [17:0] addr_q;

  // read issue tracking
  logic [SRAM_LATENCY-1:0] vld_pipe_q;
  logic [OW-1:0]           inflight;
  logic                    issue, capture;

  // word FIFO
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [OW-1:0] fifo_cnt_q;
  logic [15:0]   head;
  logic          pop;

  // unpacker and 2-entry pixel stage
  logic [1:0]  phase_q;
  logic [15:0] w0_q, w1_q;
  logic [23:0] p0, p1;
  logic        push_pair, pair_space;
  logic [23:0] ps0_q, ps1_q;
  logic [1:0]  pcnt_q;

  // interpolator and output register
  logic          take, xfer, start_acc;
  logic [23:0]   prev_q, interp;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          ov_q, sol_q, eof_q;
  logic [23:0]   rgb_q;

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8:1];
  endfunction

  assign start_acc = (state_q == S_IDLE) && Start_i && !done_q;
  assign xfer      = ov_q && Pixel_ready_i;
  assign capture   = vld_pipe_q[SRAM_LATENCY-1];
  assign issue     = (state_q == S_FETCH) &&
                     ((fifo_cnt_q + inflight) < OW'(FIFO_DEPTH));

  // count reads on the way back from SRAM; they hold FIFO credit
  always_comb begin
    inflight = '0;
    for (int i = 0; i < SRAM_LATENCY; i++) inflight = inflight + OW'(vld_pipe_q[i]);
  end

  // control FSM: frame start, address generation, completion pulse
  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= BASE_ADDR;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // a Start landing on the Done cycle is dropped via start_acc
          if (start_acc) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
            addr_q  <= BASE_ADDR;
          end
        end
        S_FETCH: begin
          // address parks on the last word so it never leaves the frame
          if (issue) begin
            if (addr_q == LAST_ADDR) state_q <= S_DRAIN;
            else                     addr_q  <= addr_q + 18'd1;
          end
        end
        S_DRAIN: begin
          // the eof pixel is the last consumer of data, so everything upstream is empty
          if (xfer && eof_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // valid tag marks which cycle's read data belongs to us
  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= issue;
      for (int i = 1; i < SRAM_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  // FIFO storage; credit check on issue guarantees no overflow
  always_ff @(posedge Clock_i) begin
    if (capture) fifo_mem[wptr_q] <= SRAM_read_data_i;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (capture) wptr_q <= wptr_q + AW'(1);
      if (pop)     rptr_q <= rptr_q + AW'(1);
      fifo_cnt_q <= fifo_cnt_q + OW'(capture) - OW'(pop);
    end
  end

  assign head       = fifo_mem[rptr_q];
  assign pair_space = (pcnt_q == 2'd0) || ((pcnt_q == 2'd1) && take);
  assign pop        = (fifo_cnt_q != '0) && ((phase_q != 2'd2) || pair_space);
  assign push_pair  = pop && (phase_q == 2'd2);
  // W0={R0,G0} W1={B0,R1} W2={G1,B1}
  assign p0         = {w0_q, w1_q[15:8]};
  assign p1         = {w1_q[7:0], head};

  // unpacker: collect W0 and W1, then emit the pair on W2
  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      phase_q <= 2'd0;
      w0_q    <= '0;
      w1_q    <= '0;
    end else if (pop) begin
      case (phase_q)
        2'd0:    begin w0_q <= head; phase_q <= 2'd1; end
        2'd1:    begin w1_q <= head; phase_q <= 2'd2; end
        default: phase_q <= 2'd0;
      endcase
    end
  end

  // pixel stage: a pair is pushed only when both slots are free after this cycle's take
  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      ps0_q  <= '0;
      ps1_q  <= '0;
      pcnt_q <= 2'd0;
    end else if (push_pair) begin
      ps0_q  <= p0;
      ps1_q  <= p1;
      pcnt_q <= 2'd2;
    end else if (take) begin
      ps0_q  <= ps1_q;
      pcnt_q <= pcnt_q - 2'd1;
    end
  end

  assign take   = (pcnt_q != 2'd0) && (!ov_q || Pixel_ready_i);
  assign interp = (col_q == '0) ? ps0_q :
                  {avg8(prev_q[23:16], ps0_q[23:16]),
                   avg8(prev_q[15:8],  ps0_q[15:8]),
                   avg8(prev_q[7:0],   ps0_q[7:0])};

  // interpolator feeding the output register; holds while stalled
  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      ov_q   <= 1'b0;
      rgb_q  <= '0;
      sol_q  <= 1'b0;
      eof_q  <= 1'b0;
      prev_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else if (start_acc) begin
      col_q <= '0;
      row_q <= '0;
    end else if (take) begin
      ov_q   <= 1'b1;
      rgb_q  <= interp;
      sol_q  <= (col_q == '0);
      eof_q  <= (col_q == COL_LAST) && (row_q == ROW_LAST);
      prev_q <= ps0_q;
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end else if (xfer) begin
      ov_q <= 1'b0;
    end
  end

`ifdef RGB_INTERP_CHECKSUM_EN
  logic [23:0] csum_q;

  // running sum of transferred pixels, frozen between frames
  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i)      csum_q <= '0;
    else if (start_acc) csum_q <= '0;
    else if (xfer)      csum_q <= csum_q + rgb_q;
  end

  assign Checksum_o = csum_q;
`else
  assign Checksum_o = '0;
`endif

  assign Busy_o         = busy_q;
  assign Done_o         = done_q;
  assign SRAM_address_o = addr_q;
  assign SRAM_we_n_o    = 1'b1;
  assign Pixel_valid_o  = ov_q;
  assign Pixel_red_o    = rgb_q[23:16];
  assign Pixel_green_o  = rgb_q[15:8];
  assign Pixel_blue_o   = rgb_q[7:0];
  assign Pixel_sol_o    = sol_q;
  assign Pixel_eof_o    = eof_q;

endmodule

// File: tb/tb_rgb_interp_pixel_fetch.sv
// Directed bench for rgb_interp_pixel_fetch on a reduced 8x4 frame.
module tb_rgb_interp_pixel_fetch;

  localparam logic [17:0] BASE = 18'h00100;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int NW = N * 3 / 2;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b0;
  logic        busy, done, we_n, valid, sol, eof;
  logic [17:0] addr;
  logic [15:0] rdata, d0, d1;
  logic [7:0]  r, g, b;
  logic [23:0] cks;

  logic [23:0] src  [N];
  logic [23:0] expv [N];
  logic [23:0] rx   [N];
  logic [23:0] exp_sum;
  int n_cmp = 0, n_fail = 0;

  always #10 clk = ~clk;

  rgb_interp_pixel_fetch #(
    .BASE_ADDR(BASE), .IMG_WIDTH(W), .IMG_HEIGHT(H), .SRAM_LATENCY(2), .FIFO_DEPTH(8)
  ) dut (
    .Clock_i(clk), .Resetn_i(rst_n), .Start_i(start), .Busy_o(busy), .Done_o(done),
    .SRAM_address_o(addr), .SRAM_we_n_o(we_n), .SRAM_read_data_i(rdata),
    .Pixel_valid_o(valid), .Pixel_ready_i(ready),
    .Pixel_red_o(r), .Pixel_green_o(g), .Pixel_blue_o(b),
    .Pixel_sol_o(sol), .Pixel_eof_o(eof), .Checksum_o(cks)
  );

  function automatic logic [7:0] byte_at(input int j);
    logic [23:0] p;
    p = src[j / 3];
    case (j % 3)
      0:       return p[23:16];
      1:       return p[15:8];
      default: return p[7:0];
    endcase
  endfunction

  function automatic logic [15:0] word_at(input logic [17:0] a);
    int i;
    if (a < BASE) return 16'hDEAD;
    i = int'(a - BASE);
    if (i >= NW) return 16'hDEAD;
    return {byte_at(2 * i), byte_at(2 * i + 1)};
  endfunction

  // SRAM model with two cycles of read latency
  always_ff @(posedge clk) begin
    d0 <= word_at(addr);
    d1 <= d0;
  end
  assign rdata = d1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", addr, BASE);
    chk("rst_we_n", we_n, 1);
    chk("rst_valid", valid, 0);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_sol_eof", {sol, eof}, 0);
    chk("rst_cks", cks, 0);
  endtask

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] c);
    return 8'((int'(a) + int'(c)) / 2);
  endfunction

  task automatic build_exp();
    exp_sum = '0;
    for (int i = 0; i < N; i++) begin
      if (i % W == 0) expv[i] = src[i];
      else expv[i] = {avg(src[i-1][23:16], src[i][23:16]),
                      avg(src[i-1][15:8],  src[i][15:8]),
                      avg(src[i-1][7:0],   src[i][7:0])};
      exp_sum = exp_sum + expv[i];
    end
  endtask

  task automatic chk_cks(input logic [23:0] e);
`ifdef RGB_INTERP_CHECKSUM_EN
    chk("checksum", cks, e);
`else
    chk("checksum_off", cks, (e & 24'h0));
`endif
  endtask

  // rmode 0: ready always high; 1: ready high about one cycle in three
  task automatic run_frame(input int rmode, input int start_at, input bit sod,
                           input int abort_at, output int ntx, output int ndone,
                           output logic [17:0] amax);
    int post;
    logic pv, pr, psol, peof;
    logic [23:0] prgb;
    ntx = 0; ndone = 0; amax = BASE; post = -1;
    pv = 1'b0; pr = 1'b0; psol = 1'b0; peof = 1'b0; prgb = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      start = 1'b0;
      if (addr > amax) amax = addr;
      if (pv && !pr)
        chk("stall_hold", {valid, sol, eof, r, g, b}, {1'b1, psol, peof, prgb});
      pv = valid; pr = ready; psol = sol; peof = eof; prgb = {r, g, b};
      if (valid && ready) begin
        if (ntx < N) begin
          chk("pixel", {r, g, b}, expv[ntx]);
          chk("sol", sol, (ntx % W == 0));
          chk("eof", eof, (ntx == N - 1));
          rx[ntx] = {r, g, b};
        end else begin
          chk("extra_transfer", ntx, N - 1);
        end
        ntx++;
        if (start_at > 0 && ntx == start_at) start = 1'b1;
      end
      if (done) begin
        ndone++;
        if (sod) start = 1'b1;
        if (post < 0) post = cyc;
      end
      if (abort_at > 0 && ntx == abort_at) break;
      if (post >= 0 && cyc > post + 20) break;
      @(negedge clk);
    end
    start = 1'b0;
    if (abort_at == 0) chk("frame_finished", (post >= 0), 1);
  endtask

  int ntx, ndone;
  logic [17:0] amax;

  initial begin
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    @(negedge clk);

    // uniform image
    for (int i = 0; i < N; i++) src[i] = 24'h0A141E;
    build_exp();
    run_frame(0, 0, 1'b0, 0, ntx, ndone, amax);
    chk("uni_transfers", ntx, N);
    chk("uni_done_count", ndone, 1);
    chk("uni_busy_after", busy, 0);
    chk("uni_addr_max", amax, BASE + NW - 1);
    chk("uni_last_pixel", rx[N-1], 24'h0A141E);
    chk_cks(24'h4283C0);

    // ramp image with hand-picked leading reds
    for (int i = 0; i < N; i++)
      src[i] = {8'(i * 37), 8'(i * 11 + 5), 8'(255 - i * 3)};
    src[0][23:16] = 8'h00;
    src[1][23:16] = 8'hFF;
    src[2][23:16] = 8'h01;
    build_exp();
    run_frame(0, 0, 1'b0, 0, ntx, ndone, amax);
    chk("ramp_r0", rx[0][23:16], 8'h00);
    chk("ramp_r1", rx[1][23:16], 8'h7F);
    chk("ramp_r2", rx[2][23:16], 8'h80);
    chk("ramp_row1_col0", rx[W], src[W]);
    chk("ramp_transfers", ntx, N);
    chk_cks(exp_sum);

    // same image with a sparse random ready
    run_frame(1, 0, 1'b0, 0, ntx, ndone, amax);
    chk("stall_transfers", ntx, N);
    chk("stall_done_count", ndone, 1);
    chk("stall_addr_max", amax, BASE + NW - 1);
    chk_cks(exp_sum);

    // reset mid-frame, then a clean restart
    run_frame(0, 0, 1'b0, 10, ntx, ndone, amax);
    chk("abort_no_done", ndone, 0);
    rst_n = 1'b0;
    #1 check_reset();
    @(posedge clk);
    #1 check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_done_quiet", done, 0);
    end
    run_frame(0, 0, 1'b0, 0, ntx, ndone, amax);
    chk("restart_first_pixel", rx[0], src[0]);
    chk("restart_transfers", ntx, N);
    chk("restart_done_count", ndone, 1);

    // Start while busy and on the Done cycle are both ignored
    run_frame(0, 10, 1'b1, 0, ntx, ndone, amax);
    chk("ign_transfers", ntx, N);
    chk("ign_done_count", ndone, 1);
    chk("ign_busy_after", busy, 0);
    chk("ign_valid_after", valid, 0);
    chk_cks(exp_sum);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
